seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Reader side of the multiplexed 7-segment display bus. Watches the anode-enable and segment
//  lines driven to the board display and turns stable segment patterns back into hex nibbles.
//  Assembles one DIGITS-wide word per full scan and offers it on a valid/ready handshake.
//  Used as an in-design loopback checker and as a bench monitor for display drivers.
// PARAMETERS
//  DIGITS  8  number of multiplexed digits (2..8); an_i and digit masks are this wide
//  SETTLE  4  consecutive identical cycles of (an_i, seg_i) required before a sample (>=2)
// PORTS
//  clk_i      in   1         system clock; all logic is on the rising edge
//  rst_i      in   1         synchronous, active-high reset
//  an_i       in   DIGITS    anode enables, active low; exactly one low bit = digit selected
//  seg_i      in   7         segments, active low; bit6=g, bit5=f ... bit0=a
//  ready_i    in   1         consumer accepts value_o when valid_o && ready_i
//  value_o    out  4*DIGITS  assembled word; digit k occupies bits [4k+3:4k]
//  bad_o      out  DIGITS    bit k set = digit k held an illegal pattern in this frame
//  valid_o    out  1         frame available; held until accepted
//  overrun_o  out  1         sticky: a completed frame was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): value_o=0, bad_o=0, valid_o=0, overrun_o=0; FSM->IDLE;
//    stability counter=0; seen mask=0; pending frame discarded. Reset wins over every event.
//  - Inputs are registered once. All stability checks compare current vs previous registered pair.
//  - Pattern table (seg_i hex -> nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7
//    00->8 10->9 08->A 03->B 46->C 21->D 06->E 0E->F. Any other code is illegal: nibble 0, bad=1.
//  - FSM (stability counter saturates at SETTLE):
//    IDLE: an_i not one-hot-low (e.g. all high = blanking) -> stay, counter=0.
//          one-hot-low -> SETTLING, counter=1.
//    SETTLING: pair unchanged -> counter+1; on reaching SETTLE capture digit, go HELD.
//              pair changed -> counter=1 if new an_i one-hot-low else IDLE.
//    HELD: pair unchanged -> stay, no further capture (one capture per dwell).
//          pair changed -> as SETTLING's change rule.
//  - Capture: writes nibble and bad bit into staging slot for the selected digit, sets its
//    seen bit. Re-capture of an already-seen digit overwrites it (latest wins).
//  - Frame complete when seen mask becomes all ones (including the capture just made).
//    Next edge: if !valid_o, or valid_o && ready_i that same cycle, staging -> value_o/bad_o,
//    valid_o=1. Otherwise the frame is dropped, value_o/bad_o unchanged, overrun_o=1.
//    In all cases the seen mask clears on that edge; staging nibbles are retained.
//  - Handshake: valid_o && ready_i at an edge with no completing frame -> valid_o=0 next
//    cycle. value_o/bad_o stable while valid_o=1. ready_i with valid_o=0 is ignored.
//  - Latency: a digit stable from cycle t (at the registered inputs) is captured at t+SETTLE-1;
//    valid_o rises the cycle after the capture completing the frame.
//  - Any mid-dwell input glitch restarts settling; a glitch shorter than SETTLE cycles never
//    causes a capture.
// TESTING
//  1. DIGITS=8, SETTLE=4: scan digits 0..7 showing 1,2,3,4,5,6,7,8 for 16 cycles each,
//     ready_i=1 -> one valid_o pulse, value_o=32'h87654321, bad_o=0, overrun_o=0.
//  2. Digit 3 shows 7F (blank) -> that frame has bad_o=8'h08 and nibble 3 = 0. All others decode.
//  3. Hold digit 2 at 12 for 3 cycles, then at 24 for 10 cycles -> only 24 captured; nibble 2 = 2.
//  4. ready_i=0 for two complete scans -> first frame held on value_o; second dropped;
//     overrun_o=1 and stays 1 until rst_i.
//  5. Frame completes on same edge valid_o && ready_i -> new word loads, valid_o stays 1,
//     no overrun.
//  6. Assert rst_i after 5 digits captured -> all outputs 0. The next full scan yields a
//     frame with only post-reset digits.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed 7-segment bus (active-low anodes/segments)
// and presents one assembled word per complete scan on a valid/ready handshake.
//
// state    | meaning
// IDLE     | no single digit selected (blanking or multiple anodes low)
// SETTLING | one digit selected, waiting for SETTLE identical cycles
// HELD     | current dwell already captured, waiting for the bus to move on
module seg7_scan_reader #(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [6:0]            seg_i,
  input  logic                  ready_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     bad_o,
  output logic                  valid_o,
  output logic                  overrun_o
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIGITS-1:0]     an_r, an_p;
  logic [6:0]            seg_r, seg_p;
  logic [DIGITS-1:0]     seen, seen_next, cap_mask;
  logic [4*DIGITS-1:0]   stage_val;
  logic [DIGITS-1:0]     stage_bad;
  logic                  frame_done;
  logic                  changed, sel_ok, capture;
  logic [IW-1:0]         sel_idx;
  logic [4:0]            dec;

  // Returns {illegal, nibble}; unknown codes decode as nibble 0 flagged bad.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    changed = (an_r != an_p) || (seg_r != seg_p);
    sel_ok  = $onehot(~an_r);
    sel_idx = '0;
    for (int k = 0; k < DIGITS; k++)
      if (!an_r[k]) sel_idx = IW'(k);
    dec      = decode(seg_r);
    capture  = (state == SETTLING) && !changed && (int'(cnt) + 1 == SETTLE);
    cap_mask = '0;
    if (capture) cap_mask[sel_idx] = 1'b1;
    seen_next = (frame_done ? '0 : seen) | cap_mask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_r       <= '1;
      an_p       <= '1;
      seg_r      <= '1;
      seg_p      <= '1;
      state      <= IDLE;
      cnt        <= '0;
      seen       <= '0;
      stage_val  <= '0;
      stage_bad  <= '0;
      frame_done <= 1'b0;
      value_o    <= '0;
      bad_o      <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      an_r       <= an_i;
      seg_r      <= seg_i;
      an_p       <= an_r;
      seg_p      <= seg_r;
      seen       <= seen_next;
      frame_done <= capture && (&seen_next);

      if (capture) begin
        stage_val[4*sel_idx +: 4] <= dec[3:0];
        stage_bad[sel_idx]        <= dec[4];
      end

      case (state)
        IDLE: begin
          if (sel_ok) begin
            state <= SETTLING;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        SETTLING, HELD: begin
          if (changed) begin
            if (sel_ok) begin
              state <= SETTLING;
              cnt   <= CW'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else if (state == SETTLING) begin
            cnt <= cnt + CW'(1);
            if (capture) state <= HELD;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // A completed frame either replaces/refills the output or is dropped.
      if (frame_done) begin
        if (!valid_o || ready_i) begin
          value_o <= stage_val;
          bad_o   <= stage_bad;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (DIGITS=8, SETTLE=4): scans words onto the bus
// and compares accepted frames against hand-computed words.
module tb_seg7_scan_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        ready;
  logic [31:0] value;
  logic [7:0]  bad;
  logic        valid;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_val = '0;
  logic [7:0]  acc_bad = '0;

  always #5 clk = ~clk;

  seg7_scan_reader #(.DIGITS(8), .SETTLE(4)) dut (
    .clk_i(clk), .rst_i(rst), .an_i(an), .seg_i(seg), .ready_i(ready),
    .value_o(value), .bad_o(bad), .valid_o(valid), .overrun_o(overrun)
  );

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
    endcase
  endfunction

  // Records any handshake that will complete at the coming edge, then advances one cycle.
  task automatic tick();
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_cnt++;
      acc_val = value;
      acc_bad = bad;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    an = '1;
    an[d] = 1'b0;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    an = '1;
    seg = 7'h7F;
    repeat (n) tick();
  endtask

  task automatic scan(input logic [31:0] w, input int dwell, input int lo, input int hi,
                      input logic [7:0] blank_mask);
    for (int k = lo; k <= hi; k++)
      show(k, blank_mask[k] ? 7'h7F : enc(w[4*k +: 4]), dwell);
  endtask

  task automatic test_reset();
    rst = 1'b1; an = '1; seg = 7'h7F; ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value got %h want %h", value, 32'h0); end
    checks++; if (bad !== 8'h0) begin errors++; $display("FAIL reset_bad got %h want %h", bad, 8'h0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    int n0;
    ready = 1'b1;
    n0 = acc_cnt;
    scan(32'h87654321, 16, 0, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL basic_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'h87654321) begin errors++; $display("FAIL basic_value got %h want 87654321", acc_val); end
    checks++; if (acc_bad !== 8'h00) begin errors++; $display("FAIL basic_bad got %h want 00", acc_bad); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", overrun); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", valid); end
  endtask

  task automatic test_bad_pattern();
    int n0;
    n0 = acc_cnt;
    scan(32'h87654321, 16, 0, 7, 8'h08);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL bad_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'h87650321) begin errors++; $display("FAIL bad_value got %h want 87650321", acc_val); end
    checks++; if (acc_bad !== 8'h08) begin errors++; $display("FAIL bad_mask got %h want 08", acc_bad); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = acc_cnt;
    scan(32'h87654321, 12, 0, 1, 8'h00);
    show(2, 7'h12, 3);
    show(2, 7'h24, 10);
    scan(32'h87654321, 12, 3, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL glitch_a_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'h87654221) begin errors++; $display("FAIL glitch_a_value got %h want 87654221", acc_val); end
    // short trailing glitch must not overwrite the settled digit
    n0 = acc_cnt;
    scan(32'h87654321, 12, 0, 1, 8'h00);
    show(2, 7'h24, 10);
    show(2, 7'h12, 3);
    scan(32'h87654321, 12, 3, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL glitch_b_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'h87654221) begin errors++; $display("FAIL glitch_b_value got %h want 87654221", acc_val); end
    checks++; if (acc_bad !== 8'h00) begin errors++; $display("FAIL glitch_b_bad got %h want 00", acc_bad); end
  endtask

  task automatic test_settle_boundary();
    int n0;
    n0 = acc_cnt;
    scan(32'hFEDCBA98, 4, 0, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL settle4_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'hFEDCBA98) begin errors++; $display("FAIL settle4_value got %h want FEDCBA98", acc_val); end
    checks++; if (acc_bad !== 8'h00) begin errors++; $display("FAIL settle4_bad got %h want 00", acc_bad); end
    n0 = acc_cnt;
    scan(32'h76543210, 3, 0, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 0) begin errors++; $display("FAIL settle3_frames got %0d want 0", acc_cnt - n0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL settle3_valid got %b want 0", valid); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    scan(32'h76543210, 8, 0, 7, 8'h00);
    blank(6);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", valid); end
    checks++; if (value !== 32'h76543210) begin errors++; $display("FAIL b2b_first_value got %h want 76543210", value); end
    scan(32'h13572468, 8, 0, 6, 8'h00);
    an = '1; an[7] = 1'b0; seg = enc(4'h1);
    repeat (5) tick();
    checks++; if (value !== 32'h76543210) begin errors++; $display("FAIL b2b_hold_value got %h want 76543210", value); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_stays got %b want 1", valid); end
    checks++; if (value !== 32'h13572468) begin errors++; $display("FAIL b2b_new_value got %h want 13572468", value); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    blank(6);
    checks++; if (valid !== 1'b0 || acc_val !== 32'h13572468) begin
      errors++; $display("FAIL b2b_drain got valid=%b val=%h want valid=0 val=13572468", valid, acc_val);
    end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    scan(32'h2468ACE0, 8, 0, 7, 8'h00);
    blank(6);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b want 1", valid); end
    checks++; if (value !== 32'h2468ACE0) begin errors++; $display("FAIL ovr_first_value got %h want 2468ACE0", value); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
    scan(32'h9BDF1357, 8, 0, 7, 8'h00);
    blank(6);
    checks++; if (value !== 32'h2468ACE0) begin errors++; $display("FAIL ovr_held_value got %h want 2468ACE0", value); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    ready = 1'b1;
    tick();
    tick();
    checks++; if (acc_val !== 32'h2468ACE0) begin errors++; $display("FAIL ovr_accept got %h want 2468ACE0", acc_val); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", valid); end
    scan(32'h0F1E2D3C, 8, 0, 7, 8'h00);
    blank(6);
    checks++; if (acc_val !== 32'h0F1E2D3C) begin errors++; $display("FAIL ovr_next_value got %h want 0F1E2D3C", acc_val); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_scan();
    int n0;
    ready = 1'b0;
    scan(32'h55AA33CC, 8, 0, 7, 8'h00);
    blank(6);
    checks++; if (valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL rst_pre got valid=%b ovr=%b want 1 1", valid, overrun);
    end
    scan(32'h11111111, 8, 0, 4, 8'h00);
    blank(2);
    rst = 1'b1;
    tick();
    tick();
    checks++; if (value !== 32'h0 || bad !== 8'h0) begin
      errors++; $display("FAIL rst_mid_data got value=%h bad=%h want 0 0", value, bad);
    end
    checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got valid=%b ovr=%b want 0 0", valid, overrun);
    end
    rst = 1'b0;
    ready = 1'b1;
    n0 = acc_cnt;
    scan(32'hC0FFEE42, 8, 5, 7, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 0 || valid !== 1'b0) begin
      errors++; $display("FAIL rst_partial got frames=%0d valid=%b want 0 0", acc_cnt - n0, valid);
    end
    scan(32'hC0FFEE42, 8, 0, 4, 8'h00);
    blank(6);
    checks++; if (acc_cnt - n0 !== 1) begin errors++; $display("FAIL rst_post_frames got %0d want 1", acc_cnt - n0); end
    checks++; if (acc_val !== 32'hC0FFEE42) begin errors++; $display("FAIL rst_post_value got %h want C0FFEE42", acc_val); end
    checks++; if (acc_bad !== 8'h00) begin errors++; $display("FAIL rst_post_bad got %h want 00", acc_bad); end
  endtask

  initial begin
    rst = 1'b1;
    an = '1;
    seg = 7'h7F;
    ready = 1'b0;
    test_reset();
    test_basic();
    test_bad_pattern();
    test_glitch();
    test_settle_boundary();
    test_back_to_back();
    test_overrun();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
